wb_gpio_irq: RTL and testbench
==============================

# wb_gpio_irq

Parametrised Wishbone B3 classic GPIO slave: the successor to the fixed 8-bit GPIO bank in the board tops. It adds configurable pin count, per-pin direction, atomic set/clear, input synchronisation, and per-pin rising/falling-edge interrupts with write-1-to-clear status. It sits on the SoC Wishbone data bus. On the DE1-SoC top it drives LEDR and the GPIO_0 header through tristate buffers that the board top builds from `gpio_o` and `gpio_oe_o`.

## Interface
- `WIDTH`, 8: number of pins, 1..32; register bits above WIDTH-1 read 0 and ignore writes.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.
- `RESET_OUT`, 0: reset value of DATA_OUT.
- `RESET_DIR`, 0: reset value of DIR (1 = output).
- `wb_clk_i  in  1`: single clock for all logic.
- `wb_rst_i  in  1`: reset, asynchronous and active-high.
- `wb_adr_i  in  5`: byte address; bits [4:2] select the register.
- `wb_dat_i  in  32`: write data.
- `wb_we_i  in  1`: write enable.
- `wb_sel_i  in  4`: ignored; all accesses are full-word.
- `wb_cyc_i`, `wb_stb_i  in  1`: bus cycle and strobe.
- `wb_dat_o  out  32`: read data, valid while `wb_ack_o` is high.
- `wb_ack_o  out  1`: acknowledge.
- `wb_err_o`, `wb_rty_o  out  1`: tied 0.
- `gpio_i  in  WIDTH`: asynchronous pin inputs.
- `gpio_o  out  WIDTH`: DATA_OUT register.
- `gpio_oe_o  out  WIDTH`: DIR register.
- `irq_o  out  1`: level interrupt, high while any bit of (STATUS & IRQ_EN) is set.

## Operation
- Register map (offset, access, function):
  - 0x00 DATA_IN, RO: synchronised `gpio_i`.
  - 0x04 DATA_OUT, RW.
  - 0x08 DIR, RW.
  - 0x0C OUT_SET, WO: ORs the written value into DATA_OUT; reads 0.
  - 0x10 OUT_CLR, WO: clears DATA_OUT bits written as 1; reads 0.
  - 0x14 IRQ_EN, RW: masks `irq_o` only; STATUS latches regardless.
  - 0x18 EDGE_RISE, RW: enables rising-edge capture per pin.
  - 0x1C, upper half-word holds EDGE_FALL: 0x1C is the combined edge register. Bits [15:0] are STATUS (W1C); bits [31:16] are EDGE_FALL. This layout limits WIDTH to 16 when fall interrupts are used.
- Edge detect runs on the synchronised value `s` and its one-cycle delay `p`. Rise = `s & ~p & EDGE_RISE`; fall = `~s & p & EDGE_FALL`. Either sets the pin's STATUS bit.
- Edge detection runs on all pins, including output pins, so software can loop back its own outputs.
- Simultaneous edge set and W1C on the same bit: set wins.
- Unmapped addresses: reads return 0; writes are ignored. Both are acked.
- Reset values: DATA_OUT=RESET_OUT, DIR=RESET_DIR; IRQ_EN, EDGE_RISE, EDGE_FALL, STATUS all 0. The synchroniser chain and `p` are preloaded to 0. `wb_ack_o`=0, `wb_dat_o`=0, `irq_o`=0.
- Reset asserted mid-cycle: ack drops immediately; the master is expected to restart the cycle.

## Timing
- Ack is registered. `wb_ack_o` rises in the cycle after `cyc&stb` is first seen high. It is held low in the following cycle, so back-to-back accesses take 2 cycles each.
- Write effect: registers update on the same edge that raises ack. `gpio_o`/`gpio_oe_o` show the new value from that edge.
- Read data is registered with ack. DATA_IN returns the synchronised value as of the cycle `stb` was sampled.
- Input latency: a pin change is visible in DATA_IN after SYNC_STAGES clock edges. The STATUS bit sets on the following edge (SYNC_STAGES+1).
- `irq_o` is a registered copy of |(STATUS & IRQ_EN): 1 cycle after STATUS sets, so SYNC_STAGES+2 edges after the pin change.
- Pulses shorter than one clock period may be missed; this is not a defect.

## Structure
- Package `wb_gpio_pkg`: register offset constants (`GPIO_DATA_IN` … `GPIO_STATUS`) and register index width. Shared with the nmon/firmware header generator.
- Sub-module `gpio_sync`: WIDTH-bit, SYNC_STAGES-deep flop chain, async reset to 0, no logic between stages.
- Top level contains the bus FSM (IDLE, ACK), the register file, the edge detect and the irq register.

## Test plan
- Reset with RESET_OUT=0xA5, RESET_DIR=0xFF: read 0x04 returns 0xA5, 0x08 returns 0xFF; `irq_o`=0; first ack arrives exactly 1 cycle after stb.
- Write 0x04=0x0F, then OUT_SET 0xF0, then OUT_CLR 0x03: `gpio_o`=0xFC; reads of 0x0C and 0x10 return 0.
- EDGE_RISE=0x01, IRQ_EN=0x01; drive `gpio_i[0]` 0→1: STATUS[0]=1 at edge 3 and `irq_o`=1 at edge 4 (SYNC_STAGES=2). Writing 0x00000001 to 0x1C clears STATUS[0] and drops `irq_o` the next cycle.
- Falling edge on pin 1 with EDGE_FALL bit 1 set, and W1C of bit 1 landing on the same cycle the edge is detected: STATUS[1] stays 1.
- Read 0x1C with WIDTH=8 and all-ones written: bits [15:8] and [31:24] read 0. An access to an unmapped address within the 5-bit space is acked and reads 0.
- Assert `wb_rst_i` mid-transfer, one cycle after stb: `wb_ack_o` is 0 that cycle and all registers return to their reset values asynchronously.

Source files
------------

// File: rtl/wb_gpio_pkg.sv
// Shared register map for the Wishbone GPIO block.
// Firmware header generators read the offsets from here as well.
package wb_gpio_pkg;

  localparam int REG_IDX_W = 3;

  localparam logic [4:0] GPIO_DATA_IN   = 5'h00;
  localparam logic [4:0] GPIO_DATA_OUT  = 5'h04;
  localparam logic [4:0] GPIO_DIR       = 5'h08;
  localparam logic [4:0] GPIO_OUT_SET   = 5'h0C;
  localparam logic [4:0] GPIO_OUT_CLR   = 5'h10;
  localparam logic [4:0] GPIO_IRQ_EN    = 5'h14;
  localparam logic [4:0] GPIO_EDGE_RISE = 5'h18;
  localparam logic [4:0] GPIO_STATUS    = 5'h1C;

  typedef enum logic [REG_IDX_W-1:0] {
    REG_DATA_IN   = 3'd0,
    REG_DATA_OUT  = 3'd1,
    REG_DIR       = 3'd2,
    REG_OUT_SET   = 3'd3,
    REG_OUT_CLR   = 3'd4,
    REG_IRQ_EN    = 3'd5,
    REG_EDGE_RISE = 3'd6,
    REG_STATUS    = 3'd7
  } reg_idx_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  function automatic reg_idx_e reg_idx(input logic [4:0] adr);
    return reg_idx_e'(adr[4:2]);
  endfunction

  // Every word slot is in use, so only byte-misaligned addresses are unmapped.
  function automatic logic adr_mapped(input logic [4:0] adr);
    return (adr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/wb_gpio_irq_if.sv
// Wishbone B3 classic bus bundle between the SoC data bus and the GPIO slave.
interface wb_gpio_irq_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_gpio_irq_sync.sv
// Plain multi-stage flop synchroniser for asynchronous pin inputs.
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_r;

  // Shift chain; stage 0 samples the raw pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO slave with per-pin direction, atomic set/clear and
// edge-triggered interrupts latched in a write-1-to-clear status register.
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_OUT   = 32'h0000_0000,
  parameter logic [31:0] RESET_DIR   = 32'h0000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_gpio_irq_if.slave     bus,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  // STATUS and EDGE_FALL share one word, so edge capture covers at most 16 pins.
  localparam int FW = (WIDTH > 16) ? 16 : WIDTH;

  bus_state_e       state_r;
  logic             ack_r;
  logic [31:0]      dat_r;
  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] irq_en_r;
  logic [WIDTH-1:0] edge_rise_r;
  logic [FW-1:0]    edge_fall_r;
  logic [FW-1:0]    status_r;
  logic [FW-1:0]    prev_r;
  logic             irq_r;

  logic [WIDTH-1:0] sync_s;
  logic             access_s;
  logic             wr_s;
  reg_idx_e         idx_s;
  logic [31:0]      rd_s;
  logic [FW-1:0]    rise_s;
  logic [FW-1:0]    fall_s;
  logic [FW-1:0]    w1c_s;
  logic [FW-1:0]    status_next_s;
  logic             unused_s;

  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (gpio_i),
    .q   (sync_s)
  );

  // Bus decode: a new access is only taken from IDLE.
  always_comb begin
    access_s = (state_r == BUS_IDLE) && bus.wb_cyc_i && bus.wb_stb_i;
    wr_s     = access_s && bus.wb_we_i && adr_mapped(bus.wb_adr_i);
    idx_s    = reg_idx(bus.wb_adr_i);
  end

  // Read mux; write-only and unmapped slots return zero.
  always_comb begin
    rd_s = 32'h0000_0000;
    if (adr_mapped(bus.wb_adr_i)) begin
      case (idx_s)
        REG_DATA_IN:   rd_s[WIDTH-1:0] = sync_s;
        REG_DATA_OUT:  rd_s[WIDTH-1:0] = data_out_r;
        REG_DIR:       rd_s[WIDTH-1:0] = dir_r;
        REG_OUT_SET:   rd_s = 32'h0000_0000;
        REG_OUT_CLR:   rd_s = 32'h0000_0000;
        REG_IRQ_EN:    rd_s[WIDTH-1:0] = irq_en_r;
        REG_EDGE_RISE: rd_s[WIDTH-1:0] = edge_rise_r;
        REG_STATUS: begin
          rd_s[FW-1:0]   = status_r;
          rd_s[16 +: FW] = edge_fall_r;
        end
        default:       rd_s = 32'h0000_0000;
      endcase
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

  // Edge detect and status update; a fresh edge beats a same-cycle clear.
  always_comb begin
    rise_s = sync_s[FW-1:0] & ~prev_r & edge_rise_r[FW-1:0];
    fall_s = ~sync_s[FW-1:0] & prev_r & edge_fall_r;
    if (wr_s && (idx_s == REG_STATUS)) begin
      w1c_s = bus.wb_dat_i[FW-1:0];
    end else begin
      w1c_s = '0;
    end
    status_next_s = (status_r & ~w1c_s) | rise_s | fall_s;
  end

  // Bus FSM: one ack cycle per access, then a mandatory idle cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= BUS_IDLE;
      ack_r   <= 1'b0;
      dat_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        BUS_IDLE: begin
          if (access_s) begin
            state_r <= BUS_ACK;
            ack_r   <= 1'b1;
            dat_r   <= rd_s;
          end else begin
            state_r <= BUS_IDLE;
            ack_r   <= 1'b0;
            dat_r   <= 32'h0000_0000;
          end
        end
        BUS_ACK: begin
          state_r <= BUS_IDLE;
          ack_r   <= 1'b0;
          dat_r   <= 32'h0000_0000;
        end
        default: begin
          state_r <= BUS_IDLE;
          ack_r   <= 1'b0;
          dat_r   <= 32'h0000_0000;
        end
      endcase
    end
  end

  // Register file, edge history and interrupt output.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      data_out_r  <= RESET_OUT[WIDTH-1:0];
      dir_r       <= RESET_DIR[WIDTH-1:0];
      irq_en_r    <= '0;
      edge_rise_r <= '0;
      edge_fall_r <= '0;
      status_r    <= '0;
      prev_r      <= '0;
      irq_r       <= 1'b0;
    end else begin
      if (wr_s) begin
        case (idx_s)
          REG_DATA_OUT:  data_out_r  <= bus.wb_dat_i[WIDTH-1:0];
          REG_DIR:       dir_r       <= bus.wb_dat_i[WIDTH-1:0];
          REG_OUT_SET:   data_out_r  <= data_out_r | bus.wb_dat_i[WIDTH-1:0];
          REG_OUT_CLR:   data_out_r  <= data_out_r & ~bus.wb_dat_i[WIDTH-1:0];
          REG_IRQ_EN:    irq_en_r    <= bus.wb_dat_i[WIDTH-1:0];
          REG_EDGE_RISE: edge_rise_r <= bus.wb_dat_i[WIDTH-1:0];
          REG_STATUS:    edge_fall_r <= bus.wb_dat_i[16 +: FW];
          default:       data_out_r  <= data_out_r;
        endcase
      end
      status_r <= status_next_s;
      prev_r   <= sync_s[FW-1:0];
      irq_r    <= |(status_r & irq_en_r[FW-1:0]);
    end
  end

  assign unused_s     = ^{bus.wb_sel_i, bus.wb_dat_i, irq_en_r, edge_rise_r};
  assign bus.wb_ack_o = ack_r;
  assign bus.wb_dat_o = dat_r;
  assign bus.wb_err_o = 1'b0;
  assign bus.wb_rty_o = 1'b0;
  assign gpio_o       = data_out_r;
  assign gpio_oe_o    = dir_r;
  assign irq_o        = irq_r;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed bench for wb_gpio_irq: register vector table plus edge/irq/reset sequences.
module tb_wb_gpio_irq;
  import wb_gpio_pkg::*;

  typedef struct {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] wdat;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_gpio;
    logic [7:0]  exp_gpio;
  } vec_t;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic [7:0] gpio_i;
  logic [7:0] gpio_o;
  logic [7:0] gpio_oe_o;
  logic       irq_o;
  int         checks   = 0;
  int         failures = 0;
  vec_t       vecs[$];

  wb_gpio_irq_if bus();

  wb_gpio_irq #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .RESET_OUT   (32'h0000_00A5),
    .RESET_DIR   (32'h0000_00FF)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .bus       (bus.slave),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe_o),
    .irq_o     (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] adr, input logic [31:0] wdat,
                              input logic chk_rd, input logic [31:0] exp_rd,
                              input logic chk_gpio, input logic [7:0] exp_gpio);
    vec_t v;
    v.we = we; v.adr = adr; v.wdat = wdat; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.chk_gpio = chk_gpio; v.exp_gpio = exp_gpio;
    return v;
  endfunction

  // One bus access; returns #1 after the edge that raised ack.
  task automatic xfer(input logic we, input logic [4:0] adr, input logic [31:0] wdat,
                      output logic [31:0] rdat);
    int n;
    logic got;
    if (bus.wb_ack_o) begin
      @(posedge wb_clk_i); #1;
    end
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr;  bus.wb_dat_i = wdat;
    n = 0; got = 1'b0;
    while (!got && n < 4) begin
      @(posedge wb_clk_i); #1;
      n++;
      if (bus.wb_ack_o) got = 1'b1;
    end
    rdat = bus.wb_dat_o;
    chk($sformatf("ack_latency_adr%02h", adr), n, 32'd1);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;

    wb_rst_i = 1'b1;
    gpio_i   = 8'h00;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 5'h00; bus.wb_dat_i = 32'h0; bus.wb_sel_i = 4'hF;

    vecs.push_back(mk(1'b0, GPIO_DATA_OUT,  32'h0,         1'b1, 32'h0000_00A5, 1'b1, 8'hA5));
    vecs.push_back(mk(1'b0, GPIO_DIR,       32'h0,         1'b1, 32'h0000_00FF, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, GPIO_IRQ_EN,    32'h0,         1'b1, 32'h0000_0000, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, GPIO_STATUS,    32'h0,         1'b1, 32'h0000_0000, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, GPIO_DATA_IN,   32'h0,         1'b1, 32'h0000_0000, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, GPIO_DATA_OUT,  32'h0000_000F, 1'b0, 32'h0,         1'b1, 8'h0F));
    vecs.push_back(mk(1'b1, GPIO_OUT_SET,   32'h0000_00F0, 1'b0, 32'h0,         1'b1, 8'hFF));
    vecs.push_back(mk(1'b1, GPIO_OUT_CLR,   32'h0000_0003, 1'b0, 32'h0,         1'b1, 8'hFC));
    vecs.push_back(mk(1'b0, GPIO_OUT_SET,   32'h0,         1'b1, 32'h0000_0000, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, GPIO_OUT_CLR,   32'h0,         1'b1, 32'h0000_0000, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, GPIO_DATA_OUT,  32'h0,         1'b1, 32'h0000_00FC, 1'b1, 8'hFC));
    vecs.push_back(mk(1'b1, GPIO_DIR,       32'h0000_003C, 1'b0, 32'h0,         1'b0, 8'h00));
    vecs.push_back(mk(1'b0, GPIO_DIR,       32'h0,         1'b1, 32'h0000_003C, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, GPIO_IRQ_EN,    32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 8'h00));
    vecs.push_back(mk(1'b0, GPIO_IRQ_EN,    32'h0,         1'b1, 32'h0000_00FF, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, GPIO_EDGE_RISE, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 8'h00));
    vecs.push_back(mk(1'b0, GPIO_EDGE_RISE, 32'h0,         1'b1, 32'h0000_00FF, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, GPIO_STATUS,    32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 8'h00));
    vecs.push_back(mk(1'b0, GPIO_STATUS,    32'h0,         1'b1, 32'h00FF_0000, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 5'h02,          32'h0,         1'b1, 32'h0000_0000, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, 5'h06,          32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, 8'hFC));
    vecs.push_back(mk(1'b0, GPIO_DATA_OUT,  32'h0,         1'b1, 32'h0000_00FC, 1'b0, 8'h00));
    vecs.push_back(mk(1'b1, GPIO_IRQ_EN,    32'h0000_0001, 1'b0, 32'h0,         1'b0, 8'h00));
    vecs.push_back(mk(1'b1, GPIO_EDGE_RISE, 32'h0000_0001, 1'b0, 32'h0,         1'b0, 8'h00));
    vecs.push_back(mk(1'b1, GPIO_STATUS,    32'h0002_0000, 1'b0, 32'h0,         1'b0, 8'h00));
    vecs.push_back(mk(1'b0, GPIO_STATUS,    32'h0,         1'b1, 32'h0002_0000, 1'b0, 8'h00));

    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("reset_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    chk("reset_dat", bus.wb_dat_o, 32'd0);
    chk("reset_irq", {31'd0, irq_o}, 32'd0);
    chk("reset_gpio_o", {24'd0, gpio_o}, 32'h0000_00A5);
    chk("reset_gpio_oe", {24'd0, gpio_oe_o}, 32'h0000_00FF);
    chk("err_rty", {30'd0, bus.wb_err_o, bus.wb_rty_o}, 32'd0);
    wb_rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, rd);
      if (vecs[i].chk_rd)   chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      if (vecs[i].chk_gpio) chk($sformatf("vec%0d_gpio", i), {24'd0, gpio_o}, {24'd0, vecs[i].exp_gpio});
      chk($sformatf("vec%0d_irq", i), {31'd0, irq_o}, 32'd0);
    end
    chk("gpio_oe_after_dir", {24'd0, gpio_oe_o}, 32'h0000_003C);

    // Rising edge on pin 0: status at edge 3, irq at edge 4.
    @(posedge wb_clk_i); #1;
    gpio_i = 8'h01;
    for (int e = 1; e <= 4; e++) begin
      @(posedge wb_clk_i); #1;
      chk($sformatf("rise_irq_edge%0d", e), {31'd0, irq_o}, (e == 4) ? 32'd1 : 32'd0);
    end
    xfer(1'b0, GPIO_DATA_IN, 32'h0, rd);
    chk("rise_data_in", rd, 32'h0000_0001);
    xfer(1'b0, GPIO_STATUS, 32'h0, rd);
    chk("rise_status", rd, 32'h0002_0001);
    xfer(1'b1, GPIO_STATUS, 32'h0002_0001, rd);
    chk("w1c_irq_same_cycle", {31'd0, irq_o}, 32'd1);
    @(posedge wb_clk_i); #1;
    chk("w1c_irq_next_cycle", {31'd0, irq_o}, 32'd0);
    xfer(1'b0, GPIO_STATUS, 32'h0, rd);
    chk("w1c_status", rd, 32'h0002_0000);

    // Falling edge on pin 1 detected on the same edge as its W1C: set wins.
    @(posedge wb_clk_i); #1;
    gpio_i = 8'h03;
    repeat (5) @(posedge wb_clk_i);
    #1;
    gpio_i = 8'h01;
    @(posedge wb_clk_i); #1;
    @(posedge wb_clk_i); #1;
    xfer(1'b1, GPIO_STATUS, 32'h0002_0002, rd);
    xfer(1'b0, GPIO_STATUS, 32'h0, rd);
    chk("fall_set_wins", rd, 32'h0002_0002);
    xfer(1'b1, GPIO_IRQ_EN, 32'h0000_0002, rd);
    chk("fall_irq_at_ack", {31'd0, irq_o}, 32'd0);
    @(posedge wb_clk_i); #1;
    chk("fall_irq_next", {31'd0, irq_o}, 32'd1);

    // Reset during an acked transfer clears everything without a clock edge.
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = GPIO_DATA_OUT;
    @(posedge wb_clk_i); #1;
    chk("midrst_ack_before", {31'd0, bus.wb_ack_o}, 32'd1);
    wb_rst_i = 1'b1;
    #1;
    chk("midrst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    chk("midrst_dat", bus.wb_dat_o, 32'd0);
    chk("midrst_irq", {31'd0, irq_o}, 32'd0);
    chk("midrst_gpio_o", {24'd0, gpio_o}, 32'h0000_00A5);
    chk("midrst_gpio_oe", {24'd0, gpio_oe_o}, 32'h0000_00FF);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    xfer(1'b0, GPIO_IRQ_EN, 32'h0, rd);
    chk("midrst_irq_en", rd, 32'h0000_0000);
    xfer(1'b0, GPIO_EDGE_RISE, 32'h0, rd);
    chk("midrst_edge_rise", rd, 32'h0000_0000);
    xfer(1'b0, GPIO_STATUS, 32'h0, rd);
    chk("midrst_status", rd, 32'h0000_0000);
    xfer(1'b0, GPIO_DATA_OUT, 32'h0, rd);
    chk("midrst_data_out", rd, 32'h0000_00A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
